// File: rtl/conv3x3_filter.sv
// 3x3 signed-kernel convolution over RGB565 columns; window -> multiply-sum -> shift/clamp/pack.
// Latency 3 cycles, one column per cycle, no backpressure; kernel swaps only at frame start.
module conv3x3_filter #(
  parameter int HRES = 1280,
  parameter int VRES = 720
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [2:0][15:0] line_buffer_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             data_valid_in,
  input  logic [8:0][7:0]  coeff_in,
  input  logic [3:0]       shift_in,
  input  logic             coeff_load_in,
  output logic [15:0]      pixel_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             data_valid_out
);
  localparam logic [10:0]      HLAST   = 11'(HRES - 1);
  localparam logic [9:0]       VLAST   = 10'(VRES - 1);
  localparam logic [8:0][7:0]  KERN_ID = {32'd0, 8'd1, 32'd0};

  logic rst_sync_q;

  logic [2:0][2:0][15:0] win_q, win_d;
  logic                  v1_q, v1_d;
  logic [10:0]           h1_q, h1_d;
  logic [9:0]            vc1_q, vc1_d;
  logic                  bord1_q, bord1_d;
  logic [9:0]            prev_v_q, prev_v_d;
  logic [8:0][7:0]       pend_k_q, pend_k_d, act_k_q, act_k_d;
  logic [3:0]            pend_sh_q, pend_sh_d, act_sh_q, act_sh_d;

  logic                  v2_q, v2_d;
  logic [10:0]           h2_q, h2_d;
  logic [9:0]            vc2_q, vc2_d;
  logic                  bord2_q, bord2_d;
  logic [3:0]            sh2_q, sh2_d;
  logic signed [19:0]    sr2_q, sr2_d, sg2_q, sg2_d, sb2_q, sb2_d;

  logic [15:0]           pix_q, pix_d;
  logic [10:0]           hout_q, hout_d;
  logic [9:0]            vout_q, vout_d;
  logic                  dv_q, dv_d;

  function automatic logic [5:0] clamp_ch(input logic signed [19:0] s, input logic [3:0] sh,
                                          input logic [5:0] maxv);
    logic signed [19:0] t;
    t = s >>> sh;
    if (t < 0) return 6'd0;
    if (t > $signed({14'd0, maxv})) return maxv;
    return t[5:0];
  endfunction

  // Deassertion is retimed by one flop so the second edge after release is usable.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= 1'b0;
    else           rst_sync_q <= 1'b1;
  end

  always_comb begin
    logic signed [19:0] acc_r, acc_g, acc_b, cf;
    logic [15:0]        px;
    logic [5:0]         cr, cg, cb;

    win_d     = win_q;
    v1_d      = data_valid_in;
    h1_d      = h1_q;
    vc1_d     = vc1_q;
    bord1_d   = bord1_q;
    prev_v_d  = prev_v_q;
    pend_k_d  = pend_k_q;
    pend_sh_d = pend_sh_q;
    act_k_d   = act_k_q;
    act_sh_d  = act_sh_q;
    v2_d      = v1_q;
    h2_d      = h2_q;
    vc2_d     = vc2_q;
    bord2_d   = bord2_q;
    sh2_d     = sh2_q;
    sr2_d     = sr2_q;
    sg2_d     = sg2_q;
    sb2_d     = sb2_q;
    pix_d     = pix_q;
    hout_d    = hout_q;
    vout_d    = vout_q;
    dv_d      = v2_q;
    acc_r     = '0;
    acc_g     = '0;
    acc_b     = '0;
    cf        = '0;
    px        = '0;

    if (coeff_load_in) begin
      pend_k_d  = coeff_in;
      pend_sh_d = shift_in;
    end

    if (data_valid_in) begin
      for (int r = 0; r < 3; r++) win_d[r] = {line_buffer_in[r], win_q[r][2], win_q[r][1]};
      prev_v_d = vcount_in;
      if (hcount_in == '0) begin
        // Column 0 closes out the previous line's right edge.
        h1_d  = HLAST;
        vc1_d = prev_v_q;
        if (vcount_in == '0) begin
          act_k_d  = pend_k_q;
          act_sh_d = pend_sh_q;
        end
      end else begin
        h1_d  = hcount_in - 11'd1;
        vc1_d = vcount_in;
      end
      bord1_d = (h1_d == '0) || (h1_d == HLAST) || (vc1_d == '0) || (vc1_d == VLAST);
    end

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px    = win_q[r][c];
        cf    = 20'(signed'(act_k_q[3*r+c]));
        acc_r = acc_r + $signed(20'(px[15:11])) * cf;
        acc_g = acc_g + $signed(20'(px[10:5]))  * cf;
        acc_b = acc_b + $signed(20'(px[4:0]))   * cf;
      end
    end

    // Shift travels with the sums so a kernel swap cannot split a pixel's math.
    if (v1_q) begin
      sr2_d   = acc_r;
      sg2_d   = acc_g;
      sb2_d   = acc_b;
      sh2_d   = act_sh_q;
      h2_d    = h1_q;
      vc2_d   = vc1_q;
      bord2_d = bord1_q;
    end

    cr = clamp_ch(sr2_q, sh2_q, 6'd31);
    cg = clamp_ch(sg2_q, sh2_q, 6'd63);
    cb = clamp_ch(sb2_q, sh2_q, 6'd31);
    if (v2_q) begin
      pix_d  = bord2_q ? 16'h0000 : {cr[4:0], cg, cb[4:0]};
      hout_d = h2_q;
      vout_d = vc2_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      win_q     <= '0;
      v1_q      <= 1'b0;
      h1_q      <= '0;
      vc1_q     <= '0;
      bord1_q   <= 1'b0;
      prev_v_q  <= '0;
      pend_k_q  <= KERN_ID;
      pend_sh_q <= '0;
      act_k_q   <= KERN_ID;
      act_sh_q  <= '0;
      v2_q      <= 1'b0;
      h2_q      <= '0;
      vc2_q     <= '0;
      bord2_q   <= 1'b0;
      sh2_q     <= '0;
      sr2_q     <= '0;
      sg2_q     <= '0;
      sb2_q     <= '0;
      pix_q     <= '0;
      hout_q    <= '0;
      vout_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      win_q     <= win_d;
      v1_q      <= v1_d;
      h1_q      <= h1_d;
      vc1_q     <= vc1_d;
      bord1_q   <= bord1_d;
      prev_v_q  <= prev_v_d;
      pend_k_q  <= pend_k_d;
      pend_sh_q <= pend_sh_d;
      act_k_q   <= act_k_d;
      act_sh_q  <= act_sh_d;
      v2_q      <= v2_d;
      h2_q      <= h2_d;
      vc2_q     <= vc2_d;
      bord2_q   <= bord2_d;
      sh2_q     <= sh2_d;
      sr2_q     <= sr2_d;
      sg2_q     <= sg2_d;
      sb2_q     <= sb2_d;
      pix_q     <= pix_d;
      hout_q    <= hout_d;
      vout_q    <= vout_d;
      dv_q      <= dv_d;
    end
  end

  assign pixel_out      = pix_q;
  assign hcount_out     = hout_q;
  assign vcount_out     = vout_q;
  assign data_valid_out = dv_q;
endmodule

// File: tb/tb_conv3x3_filter.sv
// Randomized bench for conv3x3_filter against an arithmetic reference model with a timed scoreboard.
module tb_conv3x3_filter;
  localparam int HRES = 1280;
  localparam int VRES = 720;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [2:0][15:0] line_buffer_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             data_valid_in;
  logic [8:0][7:0]  coeff_in;
  logic [3:0]       shift_in;
  logic             coeff_load_in;
  logic [15:0]      pixel_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic             data_valid_out;

  always #5 clk_in = ~clk_in;

  conv3x3_filter #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .line_buffer_in(line_buffer_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
    .coeff_in(coeff_in), .shift_in(shift_in), .coeff_load_in(coeff_load_in),
    .pixel_out(pixel_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .data_valid_out(data_valid_out)
  );

  typedef struct { int cyc; int h; int v; int pix; } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [15:0] mw [3][3];
  int   prev_v;
  int   act_k [9];
  int   pend_k [9];
  int   act_sh, pend_sh;
  int   last_pix, last_h;

  int              lda_col = -1, ldb_col = -1;
  logic [8:0][7:0] lda_k, ldb_k;
  logic [3:0]      lda_sh, ldb_sh;

  always @(posedge clk_in) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clampi(input int x, input int mx);
    return (x < 0) ? 0 : ((x > mx) ? mx : x);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mw[r][c] = '0;
    prev_v   = 0;
    act_k    = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    pend_k   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    act_sh   = 0;
    pend_sh  = 0;
    last_pix = 0;
    last_h   = 0;
    exp_q.delete();
  endtask

  // Reference: output for the centre column of the last three valid columns.
  task automatic model_step(input bit vld, input int h, input int v, input logic [2:0][15:0] col,
                            input bit ld, input logic [8:0][7:0] k, input int sh);
    exp_t e;
    int rs, gs, bs, pr, pg, pb, kk;
    if (vld && h == 0 && v == 0) begin
      act_k  = pend_k;
      act_sh = pend_sh;
    end
    if (ld) begin
      for (int i = 0; i < 9; i++) pend_k[i] = int'($signed(k[i]));
      pend_sh = sh;
    end
    if (!vld) return;
    for (int r = 0; r < 3; r++) begin
      mw[r][0] = mw[r][1];
      mw[r][1] = mw[r][2];
      mw[r][2] = col[r];
    end
    e.cyc = cyc + 3;
    if (h == 0) begin
      e.h = HRES - 1; e.v = prev_v; e.pix = 0;
    end else begin
      e.h = h - 1; e.v = v;
      if (e.h == 0 || e.h == HRES - 1 || v == 0 || v == VRES - 1) e.pix = 0;
      else begin
        rs = 0; gs = 0; bs = 0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            pr = mw[r][c][15:11]; pg = mw[r][c][10:5]; pb = mw[r][c][4:0];
            kk = act_k[3*r+c];
            rs += pr * kk; gs += pg * kk; bs += pb * kk;
          end
        end
        e.pix = (clampi(rs >>> act_sh, 31) << 11) | (clampi(gs >>> act_sh, 63) << 5)
              | clampi(bs >>> act_sh, 31);
      end
    end
    prev_v = v;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit vld, input int h, input int v, input logic [2:0][15:0] col,
                       input bit ld, input logic [8:0][7:0] k, input logic [3:0] sh);
    @(negedge clk_in);
    data_valid_in  = vld;
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    line_buffer_in = col;
    coeff_load_in  = ld;
    coeff_in       = k;
    shift_in       = sh;
    model_step(vld, h, v, col, ld, k, int'(sh));
  endtask

  task automatic load_kernel(input logic [8:0][7:0] k, input logic [3:0] sh);
    drive(1'b0, 0, 0, '0, 1'b1, k, sh);
    drive(1'b0, 0, 0, '0, 1'b0, '0, 4'd0);
  endtask

  task automatic feed_row(input int v, input bit uni, input logic [15:0] uval, input bit gaps,
                          input int ncols);
    logic [2:0][15:0] col;
    logic [8:0][7:0]  k;
    logic [3:0]       sh;
    bit               ld;
    for (int h = 0; h < ncols; h++) begin
      if (gaps && $urandom_range(7) == 0) drive(1'b0, 0, 0, '0, 1'b0, '0, 4'd0);
      for (int r = 0; r < 3; r++) col[r] = uni ? uval : 16'($urandom);
      ld = 1'b0; k = '0; sh = '0;
      if (h == lda_col) begin ld = 1'b1; k = lda_k; sh = lda_sh; end
      if (h == ldb_col) begin ld = 1'b1; k = ldb_k; sh = ldb_sh; end
      drive(1'b1, h, v, col, ld, k, sh);
    end
    drive(1'b0, 0, 0, '0, 1'b0, '0, 4'd0);
    lda_col = -1;
    ldb_col = -1;
  endtask

  function automatic logic [8:0][7:0] kfill(input int val);
    logic [8:0][7:0] k;
    for (int i = 0; i < 9; i++) k[i] = 8'(val);
    return k;
  endfunction

  function automatic logic [8:0][7:0] krand();
    logic [8:0][7:0] k;
    for (int i = 0; i < 9; i++) k[i] = 8'($urandom_range(12) - 4);
    return k;
  endfunction

  always @(negedge clk_in) begin
    if (data_valid_out) begin
      if (exp_q.size() == 0) check_eq("spurious_valid", 32'(data_valid_out), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check_eq("latency", cyc, mon_e.cyc);
        check_eq("pixel", 32'(pixel_out), mon_e.pix);
        check_eq("hcount", 32'(hcount_out), mon_e.h);
        check_eq("vcount", 32'(vcount_out), mon_e.v);
        last_pix = mon_e.pix;
        last_h   = mon_e.h;
      end
    end else begin
      check_eq("hold_pixel", 32'(pixel_out), last_pix);
      check_eq("hold_hcount", 32'(hcount_out), last_h);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [8:0][7:0] blur;
    blur = {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
    rst_n_in = 1'b0; data_valid_in = 1'b0; hcount_in = '0; vcount_in = '0;
    line_buffer_in = '0; coeff_in = '0; shift_in = '0; coeff_load_in = 1'b0;
    model_reset();
    #3;
    check_eq("reset_valid", 32'(data_valid_out), 32'd0);
    check_eq("reset_pixel", 32'(pixel_out), 32'd0);
    check_eq("reset_hcount", 32'(hcount_out), 32'd0);
    check_eq("reset_vcount", 32'(vcount_out), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;

    feed_row(5, 1'b0, 16'h0, 1'b0, HRES);
    lda_col = 600; lda_k = blur; lda_sh = 4'd4;
    feed_row(6, 1'b0, 16'h0, 1'b1, HRES);
    feed_row(0, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(9, 1'b0, 16'h0, 1'b1, HRES);

    load_kernel(kfill(1), 4'd3);
    feed_row(0, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(10, 1'b1, 16'hFFFF, 1'b0, HRES);

    load_kernel(kfill(-1), 4'd0);
    feed_row(0, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(3, 1'b1, 16'h8410, 1'b1, HRES);

    feed_row(7, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(8, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(719, 1'b0, 16'h0, 1'b0, HRES);

    lda_col = 100; lda_k = krand(); lda_sh = 4'($urandom_range(5));
    ldb_col = 900; ldb_k = krand(); ldb_sh = 4'($urandom_range(5));
    feed_row(12, 1'b0, 16'h0, 1'b1, HRES);
    lda_col = 0; lda_k = krand(); lda_sh = 4'($urandom_range(5));
    feed_row(0, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(40, 1'b0, 16'h0, 1'b1, HRES);
    feed_row(0, 1'b0, 16'h0, 1'b0, HRES);
    feed_row(41, 1'b0, 16'h0, 1'b1, HRES);

    feed_row(42, 1'b0, 16'h0, 1'b0, 500);
    @(posedge clk_in);
    #2;
    check_eq("pre_reset_valid", 32'(data_valid_out), 32'd1);
    rst_n_in = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_valid", 32'(data_valid_out), 32'd0);
    check_eq("midrst_pixel", 32'(pixel_out), 32'd0);
    check_eq("midrst_hcount", 32'(hcount_out), 32'd0);
    check_eq("midrst_vcount", 32'(vcount_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    feed_row(43, 1'b0, 16'h0, 1'b1, HRES);

    repeat (10) @(negedge clk_in);
    check_eq("drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
